asrv32_writeback_pipe: RTL
==========================

Name: asrv32_writeback_pipe

Overview:
- Parametrised, handshaked successor to the single-cycle writeback stage.
- Accepts one retiring instruction per valid/ready transfer and stalls for asynchronous load data.
- Sign/zero-extends sub-word loads, suppresses writes to x0, computes next PC (branch/jump/trap/mret) and commits rd/PC with registered outputs.
- Sits between execute/memory and the register file/fetch PC register.

Parameters:
- XLEN, 32, datapath width of rd/PC/operands (32 or 64).
- PC_RESET, {XLEN{1'b0}}, PC value after reset.
- INSTRET_W, 64, width of optional retire counter.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  stage can accept (high only in IDLE)
- i_opcode  in  `OPCODE_WIDTH  one-hot opcode (`RTYPE..`FENCE indices)
- i_funct3  in  3  funct3
- i_rd_addr  in  5  destination register index
- i_alu_result  in  XLEN  ALU output; bit0 = branch taken; [1:0] = load byte offset
- i_imm  in  XLEN  immediate
- i_rs1_data  in  XLEN  rs1 value (JALR base)
- i_csr_data  in  XLEN  CSR read value
- i_go_to_trap  in  1  take trap on this instruction
- i_return_from_trap  in  1  MRET
- i_trap_address  in  XLEN  mtvec target
- i_return_address  in  XLEN  mepc target
- i_load_data  in  XLEN  raw aligned word from data memory
- i_load_ack  in  1  load data valid (single-cycle pulse)
- o_rd_data  out  XLEN  writeback value
- o_rd_addr  out  5  writeback index
- o_wr_rd_en  out  1  regfile write strobe (1-cycle pulse)
- o_pc  out  XLEN  current PC
- o_commit  out  1  instruction retired/trapped this cycle (1-cycle pulse)
- o_instret  out  INSTRET_W  retire count (optional feature)

Behaviour:
- Reset (async): state=IDLE, o_ready=1, o_rd_data=0, o_rd_addr=0, o_wr_rd_en=0, o_commit=0, o_pc=PC_RESET, o_instret=0. Reset mid-WAIT_LOAD aborts the load: no commit, no PC change.
- States: IDLE, WAIT_LOAD.
- IDLE, i_valid&o_ready: latch all inputs.
  - Load and no trap/mret -> WAIT_LOAD.
  - Otherwise commit next cycle (outputs valid cycle N+1), stay IDLE.
- WAIT_LOAD: o_ready=0. On i_load_ack: extend data, commit next cycle, -> IDLE. A late i_load_ack arriving in IDLE is ignored.
- Next PC, priority order: trap -> i_trap_address; mret -> i_return_address; JAL -> pc+imm; JALR -> (rs1+imm)&~1; branch with alu[0]=1 -> pc+imm; else pc+4. One shared adder; all arithmetic mod 2^XLEN, wrap allowed.
- rd value:
  - R/I-type: alu.
  - LOAD: extended data.
  - JAL/JALR: pc+4.
  - LUI: imm.
  - AUIPC: pc+imm.
  - SYSTEM with funct3≠0: csr.
- Load extension uses offset off=alu[1:0] latched at accept:
  - LB: sign-extend byte off.
  - LBU: zero-extend byte off.
  - LH: sign-extend half off[1].
  - LHU: zero-extend half off[1].
  - LW: full word (sign-extended to XLEN when XLEN=64).
  - Other funct3 values are treated as LW.
- o_wr_rd_en=1 on commit unless any of: branch, store, fence, SYSTEM with funct3=0, trap, or i_rd_addr==0.
- o_rd_data/o_rd_addr are updated on every commit and hold otherwise.
- o_pc updates only on commit.
- Back-to-back: a new instruction can be accepted every cycle in IDLE; throughput is 1/cycle for non-loads.

Optional Feature:
- Macro: ASRV32_WB_INSTRET_EN.
- Defined: o_instret increments by 1 on each commit where no trap was taken (mret counts); wraps at 2^INSTRET_W.
- Undefined: counter logic is not instantiated and o_instret is tied to 0.

Test Plan:
- ADDI x5: alu=0x0000_0010, pc=0x100 -> next cycle o_wr_rd_en=1, o_rd_addr=5, o_rd_data=0x10, o_pc=0x104, o_commit=1.
- LB x6, off=3; i_load_ack after 3 cycles with data=0x80AB_CDEF -> o_ready=0 during wait; o_rd_data=0xFFFF_FF80 one cycle after ack; LBU variant gives 0x0000_0080.
- JALR x1, rs1=0x2003, imm=4, pc=0x40 -> o_rd_data=0x44, o_pc=0x2006.
- BEQ taken (alu[0]=1), imm=-8, pc=0x200 -> o_pc=0x1F8, o_wr_rd_en=0. ADDI x0 -> o_wr_rd_en=0, o_commit=1.
- i_go_to_trap=1 with i_trap_address=0x8000_0000 on a LOAD -> no WAIT_LOAD, o_pc=0x8000_0000, o_wr_rd_en=0.
- Assert reset during WAIT_LOAD, then i_load_ack -> o_pc=PC_RESET, no write, o_ready=1. With ASRV32_WB_INSTRET_EN defined, 3 commits give o_instret=3.

Source files
------------

// File: rtl/asrv32_writeback_pipe_if.sv
// Handshake and retire bus between execute/memory and the writeback stage.
// Opcode bit indices are shared with the rest of the core (one-hot encoding).
`ifndef ASRV32_OPCODES_DEFINED
`define ASRV32_OPCODES_DEFINED
`define RTYPE        0
`define ITYPE        1
`define LOAD         2
`define STORE        3
`define BRANCH       4
`define JAL          5
`define JALR         6
`define LUI          7
`define AUIPC        8
`define SYSTEM       9
`define FENCE        10
`define OPCODE_WIDTH 11
`endif

interface asrv32_writeback_pipe_if #(
   parameter int XLEN      = 32,
   parameter int INSTRET_W = 64
);
   logic                     i_valid;
   logic                     o_ready;
   logic [`OPCODE_WIDTH-1:0] i_opcode;
   logic [2:0]               i_funct3;
   logic [4:0]               i_rd_addr;
   logic [XLEN-1:0]          i_alu_result;
   logic [XLEN-1:0]          i_imm;
   logic [XLEN-1:0]          i_rs1_data;
   logic [XLEN-1:0]          i_csr_data;
   logic                     i_go_to_trap;
   logic                     i_return_from_trap;
   logic [XLEN-1:0]          i_trap_address;
   logic [XLEN-1:0]          i_return_address;
   logic [XLEN-1:0]          i_load_data;
   logic                     i_load_ack;
   logic [XLEN-1:0]          o_rd_data;
   logic [4:0]               o_rd_addr;
   logic                     o_wr_rd_en;
   logic [XLEN-1:0]          o_pc;
   logic                     o_commit;
   logic [INSTRET_W-1:0]     o_instret;

   modport master (
      output i_valid, i_opcode, i_funct3, i_rd_addr, i_alu_result, i_imm,
             i_rs1_data, i_csr_data, i_go_to_trap, i_return_from_trap,
             i_trap_address, i_return_address, i_load_data, i_load_ack,
      input  o_ready, o_rd_data, o_rd_addr, o_wr_rd_en, o_pc, o_commit, o_instret
   );

   modport slave (
      input  i_valid, i_opcode, i_funct3, i_rd_addr, i_alu_result, i_imm,
             i_rs1_data, i_csr_data, i_go_to_trap, i_return_from_trap,
             i_trap_address, i_return_address, i_load_data, i_load_ack,
      output o_ready, o_rd_data, o_rd_addr, o_wr_rd_en, o_pc, o_commit, o_instret
   );
endinterface

// File: rtl/asrv32_writeback_pipe.sv
// Handshaked writeback stage: extends loads, gates rd writes, computes and commits next PC.
// Optional retire counter enabled by defining ASRV32_WB_INSTRET_EN.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | ready; accepted non-loads commit on the following cycle
// S_WAIT_LOAD | load accepted, holding its context until i_load_ack
module asrv32_writeback_pipe #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] PC_RESET  = {XLEN{1'b0}},
   parameter int              INSTRET_W = 64
) (
   input logic                    i_clk,
   input logic                    i_rst_n,
   asrv32_writeback_pipe_if.slave bus
);

   localparam logic [0:0] S_IDLE      = 1'b0;
   localparam logic [0:0] S_WAIT_LOAD = 1'b1;

   logic [0:0]      state;
   logic            accept;
   logic            take_trap;
   logic            take_mret;
   logic            go_wait;
   logic            load_done;
   logic            wr_allowed;
   logic [XLEN-1:0] adder_base;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] link;
   logic [XLEN-1:0] next_pc;
   logic [XLEN-1:0] rd_value;
   logic [XLEN-1:0] load_ext;

   logic [XLEN-1:0] pend_pc;
   logic [4:0]      pend_rd;
   logic            pend_wr;
   logic [2:0]      pend_f3;
   logic [1:0]      pend_off;

   assign bus.o_ready = (state == S_IDLE);
   assign accept      = bus.i_valid && (state == S_IDLE);
   assign take_trap   = bus.i_go_to_trap;
   assign take_mret   = bus.i_return_from_trap && !bus.i_go_to_trap;
   assign go_wait     = bus.i_opcode[`LOAD] && !bus.i_go_to_trap && !bus.i_return_from_trap;
   assign load_done   = (state == S_WAIT_LOAD) && bus.i_load_ack;

   // Single target adder: JALR uses rs1 as base, everything else the current PC.
   assign adder_base = bus.i_opcode[`JALR] ? bus.i_rs1_data : bus.o_pc;
   assign target     = adder_base + bus.i_imm;
   assign link       = bus.o_pc + XLEN'(4);

   always_comb begin
      next_pc = link;
      if (take_trap)
         next_pc = bus.i_trap_address;
      else if (take_mret)
         next_pc = bus.i_return_address;
      else if (bus.i_opcode[`JAL])
         next_pc = target;
      else if (bus.i_opcode[`JALR])
         next_pc = {target[XLEN-1:1], 1'b0};
      else if (bus.i_opcode[`BRANCH] && bus.i_alu_result[0])
         next_pc = target;
   end

   always_comb begin
      rd_value = bus.i_alu_result;
      if (bus.i_opcode[`JAL] || bus.i_opcode[`JALR])
         rd_value = link;
      else if (bus.i_opcode[`LUI])
         rd_value = bus.i_imm;
      else if (bus.i_opcode[`AUIPC])
         rd_value = target;
      else if (bus.i_opcode[`SYSTEM] && (bus.i_funct3 != 3'b000))
         rd_value = bus.i_csr_data;
   end

   assign wr_allowed = !(bus.i_opcode[`BRANCH] || bus.i_opcode[`STORE] || bus.i_opcode[`FENCE]
                         || (bus.i_opcode[`SYSTEM] && (bus.i_funct3 == 3'b000))
                         || take_trap || (bus.i_rd_addr == 5'd0));

   // Extension works off the offset captured at accept, not the live ALU bus.
   logic        [7:0]  ld_byte;
   logic        [15:0] ld_half;
   logic        [31:0] ld_word;
   logic signed [7:0]  ld_byte_s;
   logic signed [15:0] ld_half_s;
   logic signed [31:0] ld_word_s;

   always_comb begin
      ld_byte   = bus.i_load_data[{pend_off, 3'b000} +: 8];
      ld_half   = pend_off[1] ? bus.i_load_data[31:16] : bus.i_load_data[15:0];
      ld_word   = bus.i_load_data[31:0];
      ld_byte_s = ld_byte;
      ld_half_s = ld_half;
      ld_word_s = ld_word;
      case (pend_f3)
         3'b000:  load_ext = XLEN'(ld_byte_s);
         3'b100:  load_ext = XLEN'(ld_byte);
         3'b001:  load_ext = XLEN'(ld_half_s);
         3'b101:  load_ext = XLEN'(ld_half);
         default: load_ext = XLEN'(ld_word_s);
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state          <= S_IDLE;
         bus.o_rd_data  <= '0;
         bus.o_rd_addr  <= '0;
         bus.o_wr_rd_en <= 1'b0;
         bus.o_commit   <= 1'b0;
         bus.o_pc       <= PC_RESET;
         pend_pc        <= '0;
         pend_rd        <= '0;
         pend_wr        <= 1'b0;
         pend_f3        <= '0;
         pend_off       <= '0;
      end else begin
         bus.o_commit   <= 1'b0;
         bus.o_wr_rd_en <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  if (go_wait) begin
                     state    <= S_WAIT_LOAD;
                     pend_pc  <= next_pc;
                     pend_rd  <= bus.i_rd_addr;
                     pend_wr  <= wr_allowed;
                     pend_f3  <= bus.i_funct3;
                     pend_off <= bus.i_alu_result[1:0];
                  end else begin
                     bus.o_rd_data  <= rd_value;
                     bus.o_rd_addr  <= bus.i_rd_addr;
                     bus.o_wr_rd_en <= wr_allowed;
                     bus.o_pc       <= next_pc;
                     bus.o_commit   <= 1'b1;
                  end
               end
            end
            S_WAIT_LOAD: begin
               if (bus.i_load_ack) begin
                  state          <= S_IDLE;
                  bus.o_rd_data  <= load_ext;
                  bus.o_rd_addr  <= pend_rd;
                  bus.o_wr_rd_en <= pend_wr;
                  bus.o_pc       <= pend_pc;
                  bus.o_commit   <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef ASRV32_WB_INSTRET_EN
   // Traps do not retire; mret does.
   logic                 retire;
   logic [INSTRET_W-1:0] instret;

   assign retire = (accept && !go_wait && !take_trap) || load_done;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         instret <= '0;
      else if (retire)
         instret <= instret + INSTRET_W'(1);
   end

   assign bus.o_instret = instret;
`else
   logic unused_load_done;
   assign unused_load_done = load_done;
   assign bus.o_instret    = {INSTRET_W{1'b0}};
`endif

endmodule
